// File: rtl/gerador_sync_vga_pkg.sv
// -----------------------------------------------------------------------------
// gerador_sync_vga_pkg
//   Shared raster timing constants for the VGA sync generator: default
//   640x480@60 horizontal/vertical timing, sync polarity constants and a
//   helper that derives the total line/frame length from its four segments.
//   No ports (package).
// -----------------------------------------------------------------------------
package gerador_sync_vga_pkg;

    // Default 640x480@60 timing (25.175 MHz pixel rate)
    localparam int VGA_WIDTH    = 10;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Asserted level of hsync/vsync
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Total length of a line or frame made of active + porches + sync.
    function automatic int total_len(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = total_len(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = total_len(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/gerador_sync_vga_comparador.sv
// -----------------------------------------------------------------------------
// comparador_menor_const
//   Combinational test a < LIMITE against a constant, built as an MSB-first
//   equal/less cascade so each window edge costs only a small gate chain.
//   Ports:
//     a      in   WIDTH  value under test
//     menor  out  1      1 iff a < LIMITE
// -----------------------------------------------------------------------------
module comparador_menor_const
    import gerador_sync_vga_pkg::*;
#(
    parameter int WIDTH  = VGA_WIDTH,
    parameter int LIMITE = 0
) (
    input  logic [WIDTH-1:0] a,
    output logic             menor
);

    generate
        if (LIMITE <= 0) begin : g_never
            // Nothing unsigned is below zero
            logic unused_a;
            assign unused_a = ^a;
            assign menor    = 1'b0;
        end else if ((LIMITE >> WIDTH) != 0) begin : g_always
            // Limit beyond the representable range: every value is below it
            logic unused_a;
            assign unused_a = ^a;
            assign menor    = 1'b1;
        end else begin : g_cascade
            localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMITE);

            // eq[i+1]: bits above i all equal the limit; lt[i]: a already
            // decided smaller at or above bit i.
            logic [WIDTH:1] eq;
            logic [WIDTH:0] lt;

            assign eq[WIDTH] = 1'b1;
            assign lt[WIDTH] = 1'b0;

            for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_bit
                assign lt[i] = lt[i+1] | (eq[i+1] & ~a[i] & LIM[i]);
                if (i > 0) begin : g_eq
                    assign eq[i] = eq[i+1] & (a[i] == LIM[i]);
                end
            end

            assign menor = lt[0];
        end
    endgenerate

endmodule

// File: rtl/gerador_sync_vga.sv
// -----------------------------------------------------------------------------
// gerador_sync_vga
//   Parametrised raster timing generator. Horizontal/vertical pixel counters
//   advance on pix_en; hsync, vsync, video_on and line/frame strobes are
//   registered from the next counter values so they line up with x,y.
//   Ports:
//     clk          in   1      system clock
//     rst_n        in   1      synchronous reset, active-low
//     pix_en       in   1      pixel-rate enable
//     x            out  WIDTH  current column, 0..H_TOTAL-1
//     y            out  WIDTH  current line, 0..V_TOTAL-1
//     hsync        out  1      horizontal sync, SYNC_POL level inside window
//     vsync        out  1      vertical sync, SYNC_POL level inside window
//     video_on     out  1      1 iff x<H_ACTIVE and y<V_ACTIVE
//     line_start   out  1      one-clk pulse when x becomes 0
//     frame_start  out  1      one-clk pulse when (x,y) becomes (0,0)
// -----------------------------------------------------------------------------
module gerador_sync_vga
    import gerador_sync_vga_pkg::*;
#(
    parameter int   WIDTH    = VGA_WIDTH,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL      = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [WIDTH-1:0] X_MAX = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] Y_MAX = WIDTH'(V_TOTAL - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    generate
        if ((H_TOTAL - 1) > ((2 ** WIDTH) - 1)) begin : g_h_overflow
            $error("gerador_sync_vga: H_TOTAL-1 does not fit in WIDTH bits");
        end
        if ((V_TOTAL - 1) > ((2 ** WIDTH) - 1)) begin : g_v_overflow
            $error("gerador_sync_vga: V_TOTAL-1 does not fit in WIDTH bits");
        end
    endgenerate

    logic [WIDTH-1:0] x_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic             x_wrap;
    logic             y_wrap;

    assign x_wrap = (x == X_MAX);
    assign y_wrap = (y == Y_MAX);

    // Next counter values; outputs are decoded from these so they are
    // registered in step with x and y.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (pix_en) begin
            if (x_wrap) begin
                x_nxt = '0;
                y_nxt = y_wrap ? '0 : y + ONE;
            end else begin
                x_nxt = x + ONE;
            end
        end
    end

    logic x_lt_active, x_lt_sync_start, x_lt_sync_end;
    logic y_lt_active, y_lt_sync_start, y_lt_sync_end;

    comparador_menor_const #(.WIDTH(WIDTH), .LIMITE(H_ACTIVE))
        u_x_active     (.a(x_nxt), .menor(x_lt_active));
    comparador_menor_const #(.WIDTH(WIDTH), .LIMITE(H_SYNC_START))
        u_x_sync_start (.a(x_nxt), .menor(x_lt_sync_start));
    comparador_menor_const #(.WIDTH(WIDTH), .LIMITE(H_SYNC_END))
        u_x_sync_end   (.a(x_nxt), .menor(x_lt_sync_end));
    comparador_menor_const #(.WIDTH(WIDTH), .LIMITE(V_ACTIVE))
        u_y_active     (.a(y_nxt), .menor(y_lt_active));
    comparador_menor_const #(.WIDTH(WIDTH), .LIMITE(V_SYNC_START))
        u_y_sync_start (.a(y_nxt), .menor(y_lt_sync_start));
    comparador_menor_const #(.WIDTH(WIDTH), .LIMITE(V_SYNC_END))
        u_y_sync_end   (.a(y_nxt), .menor(y_lt_sync_end));

    logic h_in_sync;
    logic v_in_sync;

    assign h_in_sync = !x_lt_sync_start && x_lt_sync_end;
    assign v_in_sync = !y_lt_sync_start && y_lt_sync_end;

    // Reset parks the counters on the last pixel so the first pix_en wraps
    // to (0,0) and raises frame_start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x           <= X_MAX;
            y           <= Y_MAX;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
            video_on    <= x_lt_active && y_lt_active;
            line_start  <= pix_en && x_wrap;
            frame_start <= pix_en && x_wrap && y_wrap;
        end
    end

endmodule

// File: tb/tb_gerador_sync_vga.sv
// -----------------------------------------------------------------------------
// tb_gerador_sync_vga
//   Bench for the raster generator with two instances sharing stimulus:
//   default 640x480 timing and a tiny 14x7 active-high configuration.
//   The reference model counts pixel advances since reset and derives x,y
//   and every output from that count with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_gerador_sync_vga;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    always #5 clk = ~clk;

    logic [9:0] x_a, y_a;
    logic       hs_a, vs_a, von_a, ls_a, fs_a;
    logic [3:0] x_b, y_b;
    logic       hs_b, vs_b, von_b, ls_b, fs_b;

    gerador_sync_vga u_dut_vga (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    gerador_sync_vga #(
        .WIDTH(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) u_dut_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Reference model: number of pixel advances since the last reset
    longint k      = 0;
    bit     adv    = 1'b0;
    bit     mvalid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            k      <= 0;
            mvalid <= 1'b1;
        end else if (pix_en) begin
            k <= k + 1;
        end
        adv <= rst_n && pix_en;
    end

    function automatic logic [31:0] model_out(int ha, int hf, int hs, int hb,
                                              int va, int vf, int vs, int vb,
                                              bit pol, longint kk, bit a);
        int     ht = ha + hf + hs + hb;
        int     vt = va + vf + vs + vb;
        longint idx;
        int     xm, ym;
        bit     h, v, von, ls, fs;
        if (kk == 0) begin
            xm  = ht - 1;
            ym  = vt - 1;
            idx = -1;
        end else begin
            idx = (kk - 1) % (ht * vt);
            xm  = int'(idx % ht);
            ym  = int'(idx / ht);
        end
        h   = (xm >= ha + hf && xm < ha + hf + hs) ? pol : !pol;
        v   = (ym >= va + vf && ym < va + vf + vs) ? pol : !pol;
        von = (xm < ha) && (ym < va);
        ls  = a && (xm == 0);
        fs  = a && (idx == 0);
        return {12'(xm), 12'(ym), h, v, von, ls, fs, 3'b000};
    endfunction

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("vga_cycle",
                {12'(x_a), 12'(y_a), hs_a, vs_a, von_a, ls_a, fs_a, 3'b000},
                model_out(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, k, adv));
            chk("small_cycle",
                {12'(x_b), 12'(y_b), hs_b, vs_b, von_b, ls_b, fs_b, 3'b000},
                model_out(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, k, adv));
        end
    end

    // mode 0: pix_en=1, 1: alternating 1/0, 2: random with rare resets.
    // exp_lp / exp_fp = expected line (vga) / frame (small) period, 0 = skip.
    task automatic measure(int n, int mode, int exp_lp, int exp_fp);
        int last_ls = -1, last_fs = -1;
        int hs_cnt = 0, von_cnt = 0, vs_cnt = 0, bad = 0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       pix_en = 1'b1;
                1:       pix_en = ((i % 2) == 0);
                default: begin
                    pix_en = ($urandom_range(0, 3) != 0);
                    rst_n  = ($urandom_range(0, 499) != 0);
                end
            endcase
            @(negedge clk);
            if (hs_a == 1'b0 && (x_a < 656 || x_a > 751)) bad++;
            if (vs_b == 1'b1 && y_b != 5) bad++;
            if (ls_a) begin
                if (last_ls >= 0 && exp_lp > 0) begin
                    chk("line_period", i - last_ls, exp_lp);
                    chk("hsync_low_per_line", hs_cnt, 96 * exp_lp / 800);
                end
                last_ls = i;
                hs_cnt  = 0;
            end
            if (fs_b) begin
                if (last_fs >= 0 && exp_fp > 0) begin
                    chk("frame_period", i - last_fs, exp_fp);
                    chk("video_on_per_frame", von_cnt, 32 * exp_fp / 98);
                    chk("vsync_per_frame", vs_cnt, 14 * exp_fp / 98);
                end
                last_fs = i;
                von_cnt = 0;
                vs_cnt  = 0;
            end
            if (hs_a == 1'b0) hs_cnt++;
            if (von_b) von_cnt++;
            if (vs_b) vs_cnt++;
        end
        rst_n = 1'b1;
        chk("window_rule", bad, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        pix_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_x_vga", x_a, 799);
        chk("idle_y_vga", y_a, 524);
        chk("idle_sync_vga", {hs_a, vs_a}, 2'b11);
        chk("idle_von_strobes_vga", {von_a, ls_a, fs_a}, 3'b000);
        chk("idle_x_small", x_b, 13);
        chk("idle_y_small", y_b, 6);
        chk("idle_sync_small", {hs_b, vs_b}, 2'b00);

        pix_en = 1'b1;
        @(negedge clk);
        chk("first_xy_vga", {x_a, y_a}, 20'd0);
        chk("first_strobes_vga", {ls_a, fs_a, von_a, hs_a}, 4'b1111);
        chk("first_xy_small", {x_b, y_b}, 8'd0);
        chk("first_fs_small", fs_b, 1);
        @(negedge clk);
        chk("second_x_vga", x_a, 1);
        chk("second_strobes_vga", {ls_a, fs_a}, 2'b00);

        measure(2400, 0, 800, 98);
        measure(3400, 1, 1600, 196);
        measure(3000, 2, 0, 0);

        // Mid-line reset with pix_en high
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pix_en = 1'b1;
        repeat (1901) @(negedge clk);
        chk("pos_x_vga", x_a, 300);
        chk("pos_y_vga", y_a, 2);
        chk("pos_xy_small", {x_b, y_b}, {4'd10, 4'd2});
        chk("pos_hsync_small", hs_b, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_xy_vga", {x_a, y_a}, {10'd799, 10'd524});
        chk("midrst_outs_vga", {hs_a, vs_a, von_a, ls_a, fs_a}, 5'b11000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_xy_vga", {x_a, y_a}, 20'd0);
        chk("after_rst_strobes_vga", {ls_a, fs_a}, 2'b11);
        pix_en = 1'b0;
        @(negedge clk);
        chk("hold_x_vga", x_a, 0);
        chk("hold_strobes_vga", {ls_a, fs_a, ls_b, fs_b}, 4'b0000);

        pix_en = 1'b1;
        repeat (73) @(negedge clk);
        chk("vsync_line_small", {y_b, vs_b, von_b}, {4'd5, 1'b1, 1'b0});
        chk("line0_vga", {x_a, y_a, von_a}, {10'd73, 10'd0, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
